// File: rtl/retire_trace_pkg.sv
// retire_trace_pkg: shared widths, stage and trace record types for the retirement trace buffer
package retire_trace_pkg;
    localparam int PC_W     = 16;
    localparam int INSTR_W  = 16;
    localparam int TAG_W    = 7;
    localparam int CYC_W    = 32;
    localparam int DEPTH    = 8;
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int DROP_MAX = 255;

    typedef struct packed {
        logic               valid;
        logic [TAG_W-1:0]   tag;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } stage_rec_t;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [CYC_W-1:0]   cycle;
    } trace_rec_t;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: DEPTH-entry FIFO of trace records; a push into a full FIFO succeeds only alongside a pop
module trace_fifo
    import retire_trace_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  trace_rec_t       wr_i,
    output trace_rec_t       rd_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);

    trace_rec_t       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty_o = count_q == '0;
    assign full_o  = count_q == CNT_W'(DEPTH);
    assign count_o = count_q;
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rd_o    = empty_o ? '0 : mem_q[rd_ptr_q];

    // pointers and occupancy; reset discards every queued record
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q <= do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
            count_q  <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // record storage, left unreset since empty masks stale entries
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_i;
    end
endmodule

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: tags fetched instructions, tracks them IF..WB under stall/flush, queues retirement records
// Optional feature macro RETIRE_TRACE_CYCLE_EN: enables the cycle counter and retirement stamps.
module retire_trace_buffer
    import retire_trace_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    fetch_pc,
    input  logic [INSTR_W-1:0] fetch_instr,
    input  logic               stall,
    input  logic               flush,
    output logic               trace_valid,
    input  logic               trace_ready,
    output logic [TAG_W-1:0]   trace_tag,
    output logic [PC_W-1:0]    trace_pc,
    output logic [INSTR_W-1:0] trace_instr,
    output logic [CYC_W-1:0]   trace_cycle,
    output logic [CNT_W-1:0]   trace_count,
    output logic               overflow,
    output logic [7:0]         drop_count
);
    stage_rec_t       if_q, id_q, ex_q, mm_q;
    stage_rec_t       if_d, id_d, ex_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [CYC_W-1:0] stamp;
    logic             overflow_q;
    logic [7:0]       drop_q;
    trace_rec_t       wr_rec, rd_rec;
    logic             full, empty, pop, drop;

`ifdef RETIRE_TRACE_CYCLE_EN
    logic [CYC_W-1:0] cyc_q;

    // free-running cycle counter used to stamp retirements
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cyc_q <= '0;
        else cyc_q <= cyc_q + CYC_W'(1);
    end

    assign stamp = cyc_q;
`else
    assign stamp = '0;
`endif

    // stall freezes IF/ID and bubbles EX; flush squashes IF on its way into ID
    always_comb begin
        if_d  = stall ? if_q : stage_rec_t'{valid: 1'b1, tag: tag_q, pc: fetch_pc, instr: fetch_instr};
        id_d  = stall ? id_q : (flush ? '0 : if_q);
        ex_d  = stall ? '0 : id_q;
        tag_d = stall ? tag_q : tag_q + TAG_W'(1);
    end

    // stage registers and tag generator; MEM advances every edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_q  <= '0;
            id_q  <= '0;
            ex_q  <= '0;
            mm_q  <= '0;
            tag_q <= '0;
        end else begin
            if_q  <= if_d;
            id_q  <= id_d;
            ex_q  <= ex_d;
            mm_q  <= ex_q;
            tag_q <= tag_d;
        end
    end

    assign wr_rec = trace_rec_t'{tag: mm_q.tag, pc: mm_q.pc, instr: mm_q.instr, cycle: stamp};
    assign pop    = trace_ready & ~empty;
    assign drop   = mm_q.valid & full & ~pop;

    trace_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (mm_q.valid),
        .pop_i   (trace_ready),
        .wr_i    (wr_rec),
        .rd_o    (rd_rec),
        .full_o  (full),
        .empty_o (empty),
        .count_o (trace_count)
    );

    // sticky overflow flag and saturating drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            drop_q     <= drop_q == 8'(DROP_MAX) ? drop_q : drop_q + 8'd1;
        end
    end

    assign trace_valid = ~empty;
    assign trace_tag   = rd_rec.tag;
    assign trace_pc    = rd_rec.pc;
    assign trace_instr = rd_rec.instr;
    assign trace_cycle = rd_rec.cycle;
    assign overflow    = overflow_q;
    assign drop_count  = drop_q;
endmodule

// File: doc/retire_trace_buffer.md
# retire_trace_buffer

- Synthesizable pipeline-side producer of per-instruction retirement trace records for the 5-stage CPU (IF/ID/EX/MEM/WB).
- Assigns a sequence tag to every fetched instruction and carries tag, PC and instruction word through the stages, honouring the core's stall and flush.
- Pushes one record into an internal FIFO per instruction reaching WB.
- Bench monitors and future on-chip debug logic drain the FIFO over a valid/ready port.

## Interface
- PC_W, 16, PC width
- INSTR_W, 16, instruction word width
- TAG_W, 7, sequence tag width (wraps modulo 2^TAG_W)
- CYC_W, 32, cycle stamp width
- DEPTH, 8, FIFO entries (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- fetch_pc  in  PC_W  PC of instruction fetched this cycle
- fetch_instr  in  INSTR_W  instruction fetched this cycle
- stall  in  1  hold IF and ID, inject bubble into EX
- flush  in  1  squash instruction currently in IF (wrong path)
- trace_valid  out  1  FIFO head record available
- trace_ready  in  1  reader accepts head record
- trace_tag  out  TAG_W  head record tag
- trace_pc  out  PC_W  head record PC
- trace_instr  out  INSTR_W  head record instruction
- trace_cycle  out  CYC_W  head record retirement stamp
- trace_count  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: a record was dropped
- drop_count  out  8  dropped records, saturates at 255

## Operation
- Reset values: all stage valids 0, next_tag 0, cycle counter 0, FIFO empty, trace_valid 0, trace_count 0, overflow 0, drop_count 0. Data outputs are 0 while empty.
- Cycle counter increments on every edge after reset; wraps at 2^CYC_W.
- Stage register contents: {valid, tag, pc, instr}.
- Per edge with stall=0:
  - IF loads {1, next_tag, fetch_pc, fetch_instr}; next_tag increments.
  - ID loads IF, or a bubble if flush=1.
  - EX loads ID.
- Per edge with stall=1:
  - IF, ID and next_tag hold; EX loads a bubble.
  - flush is ignored; stall wins.
- MEM←EX and WB←MEM advance every edge.
- Squashed tags are consumed, never reused, so gaps are visible in the trace.
- Push: on an edge where MEM is valid, the record {tag, pc, instr, cycle counter pre-edge value} is written to the FIFO as WB loads.
- Pop: on an edge with trace_valid & trace_ready.
- Full FIFO:
  - Push without pop: record dropped, overflow set, drop_count increments (saturating).
  - Push with pop: both occur, nothing dropped, count unchanged.
- Pop while empty has no effect.
- Tag wrap: 2^TAG_W−1 is followed by 0.

## Timing
- Instruction fetched at edge N: IF at N, ID N+1, EX N+2, MEM N+3, pushed at N+4 with stamp = counter value just before edge N+4.
- trace_valid rises after the push edge; zero-cycle FIFO bypass is prohibited.
- Each stall edge adds 1 cycle of latency to instructions in IF/ID.
- Head outputs are registered FIFO read data and stable while trace_valid=1 and trace_ready=0.
- rst assertion mid-operation: immediately clears all state and outputs to reset values, including queued records; no partial record survives.

## Configuration
- RETIRE_TRACE_CYCLE_EN defined: cycle counter instantiated, stamps stored in the FIFO, trace_cycle driven.
- RETIRE_TRACE_CYCLE_EN undefined: counter and stamp storage removed, trace_cycle tied to 0. Port list is unchanged.

## Structure
- Package retire_trace_pkg:
  - stage_rec_t struct {valid, tag, pc, instr}
  - trace_rec_t struct {tag, pc, instr, cycle}
  - parameter defaults
  - DROP_MAX = 255
- Sub-module trace_fifo: synchronous DEPTH-entry FIFO of trace_rec_t with push/pop, full/empty, count, simultaneous push/pop when full. The top keeps stage tracking, tag generation, drop accounting.

## Test plan
- Reset: hold rst, then release. Required: all outputs 0, trace_valid 0, count 0.
- Straight-line: fetches at edges 1–3 with trace_ready=1. Required: records tags 0,1,2 with stamps 4,5,6 and matching pc/instr.
- Stall: stall=1 sampled at edges 3–4, fetching from edge 1. Required: tags 0,1,2 stamped 6,7,8; no duplicate tags.
- Flush: flush=1 sampled at edge 3. Required: tag 0 stamped 4, tag 2 stamped 6, tag 1 never appears.
- Overflow: trace_ready=0 with DEPTH+3 instructions retiring. Required:
  - count=DEPTH, overflow=1, drop_count=3.
  - Draining yields tags 0..DEPTH−1 in order.
  - Push+pop when full drops nothing.
- Mid-run reset: assert rst with 3 records queued and the pipeline full. Required: trace_valid 0 immediately; after release, tags restart at 0 and stamps at 4.
